// File: rtl/mm_timeout_guard.sv
// mm_timeout_guard: zero-latency MemoryMapped pass-through that aborts a
// transaction with an error data word when the slave stalls too long, and
// records the failing access plus a saturating abort count for debug.
module mm_timeout_guard #(
    parameter int                AWIDTH  = 8,
    parameter int                DWIDTH  = 8,
    parameter int                TIMEOUT = 256,
    parameter logic [DWIDTH-1:0] ERRDATA = '1,
    parameter int                CWIDTH  = 8
) (
    input  logic              reset,
    input  logic              clk,
    input  logic [AWIDTH-1:0] s_addr,
    input  logic              s_wreq,
    input  logic [DWIDTH-1:0] s_wdat,
    input  logic              s_rreq,
    output logic [DWIDTH-1:0] s_rdat,
    output logic              s_rdyn,
    output logic [AWIDTH-1:0] m_addr,
    output logic              m_wreq,
    output logic [DWIDTH-1:0] m_wdat,
    output logic              m_rreq,
    input  logic [DWIDTH-1:0] m_rdat,
    input  logic              m_rdyn,
    input  logic              err_clr,
    output logic              err_pulse,
    output logic [AWIDTH-1:0] err_addr,
    output logic              err_wr,
    output logic [CWIDTH-1:0] err_cnt
);

    // A zero TIMEOUT still needs a 1-bit counter to keep the code legal.
    localparam int              CNTW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNTW-1:0] TMAX = CNTW'(TIMEOUT);
    localparam bit              GUARD_EN = (TIMEOUT != 0);

    typedef enum logic {PASS = 1'b0, BLANK = 1'b1} state_t;

    state_t          state;
    logic [CNTW-1:0] cnt;
    logic            req;
    logic            stall;
    logic            abort;

    assign req   = s_wreq | s_rreq;
    assign stall = (state == PASS) & req & m_rdyn;
    assign abort = GUARD_EN & ~reset & stall & (cnt == TMAX);

    assign m_addr = s_addr;
    assign m_wdat = s_wdat;

    // Combinational request/response steering: reset and BLANK hide the
    // master from the slave, an abort completes towards the master with ERRDATA.
    always_comb begin
        m_wreq = s_wreq;
        m_rreq = s_rreq;
        s_rdyn = m_rdyn;
        s_rdat = m_rdat;
        if (reset || state == BLANK) begin
            m_wreq = 1'b0;
            m_rreq = 1'b0;
            s_rdyn = 1'b1;
        end else if (abort) begin
            m_wreq = 1'b0;
            m_rreq = 1'b0;
            s_rdyn = 1'b0;
            s_rdat = ERRDATA;
        end
    end

    // State and stall counter; BLANK always lasts a single cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= PASS;
            cnt   <= '0;
        end else begin
            case (state)
                PASS:    state <= abort ? BLANK : PASS;
                default: state <= PASS;
            endcase
            // Holding at TMAX only matters when the guard is disabled.
            if (stall && !abort)
                cnt <= (cnt == TMAX) ? cnt : cnt + 1'b1;
            else
                cnt <= '0;
        end
    end

    // Debug capture of the aborted access and the saturating abort count.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_pulse <= 1'b0;
            err_addr  <= '0;
            err_wr    <= 1'b0;
            err_cnt   <= '0;
        end else begin
            err_pulse <= abort;
            if (abort) begin
                err_addr <= s_addr;
                err_wr   <= s_wreq;
            end
            if (err_clr)
                err_cnt <= abort ? CWIDTH'(1) : '0;
            else if (abort && !(&err_cnt))
                err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: doc/mm_timeout_guard.md
Name: mm_timeout_guard

Overview:
Single-clock MemoryMapped stage placed directly downstream of the clock-domain handshake synchronizer, between its master side and the target slave. It passes transactions through with zero latency. It watches how long the slave holds wait-request and, if the slave stalls beyond a programmable limit, terminates the transaction towards the master with an error data word. This stops a dead slave from hanging the synchronizer and the remote bus indefinitely. It also records the failing access and counts timeouts for debug.

Parameters:
AWIDTH, 8, address width
DWIDTH, 8, data width
TIMEOUT, 256, stall cycles tolerated before abort; 0 disables the guard (pure pass-through)
ERRDATA, all-ones (DWIDTH bits), read data returned on an aborted transaction
CWIDTH, 8, width of the timeout event counter

Ports:
reset  input  1  synchronous active-high reset
clk  input  1  clock
s_addr  input  AWIDTH  slave-side address (from upstream master)
s_wreq  input  1  write request
s_wdat  input  DWIDTH  write data
s_rreq  input  1  read request
s_rdat  output  DWIDTH  read data
s_rdyn  output  1  wait-request (1 = not ready)
m_addr  output  AWIDTH  address to target slave
m_wreq  output  1  write request to slave
m_wdat  output  DWIDTH  write data to slave
m_rreq  output  1  read request to slave
m_rdat  input  DWIDTH  read data from slave
m_rdyn  input  1  slave wait-request
err_clr  input  1  clears err_cnt
err_pulse  output  1  one-cycle pulse, cycle after an abort
err_addr  output  AWIDTH  address of last aborted access
err_wr  output  1  1 = last aborted access was a write, 0 = read
err_cnt  output  CWIDTH  saturating count of aborts

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Bus protocol: the master holds addr/wdat/wreq/rreq stable while s_rdyn=1. A transfer completes in the cycle where (wreq|rreq) & ~rdyn. Read data is valid in that cycle only. wreq and rreq are never both 1.
- Pass-through: m_addr=s_addr and m_wdat=s_wdat at all times.
- States: PASS, BLANK. Reset state is PASS.
- In PASS, when no abort is occurring: m_wreq=s_wreq, m_rreq=s_rreq, s_rdyn=m_rdyn, s_rdat=m_rdat. All paths are combinational, zero added latency.
- Stall counter cnt, width clog2(TIMEOUT+1), reset 0:
  - In PASS, if req & m_rdyn: cnt <= cnt+1.
  - Otherwise: cnt <= 0. This covers completion, idle, and the abort cycle.
- Abort condition: PASS & req & m_rdyn & (cnt==TIMEOUT) & (TIMEOUT!=0). The abort therefore fires in the (TIMEOUT+1)-th consecutive stalled cycle.
- In the abort cycle:
  - m_wreq=m_rreq=0.
  - s_rdyn=0, so the master sees completion.
  - s_rdat=ERRDATA.
  - Next state is BLANK.
- BLANK lasts exactly 1 cycle:
  - m_wreq=m_rreq=0 and s_rdyn=1. The slave sees one request-free cycle.
  - cnt=0.
  - Next state is PASS.
- Simultaneous events:
  - m_rdyn=0 in the cycle cnt==TIMEOUT: normal completion, no abort.
  - err_clr together with an abort: err_cnt <= 1.
- Error registers (reset: err_pulse=0, err_addr=0, err_wr=0, err_cnt=0):
  - In the cycle after an abort: err_pulse=1, err_addr=s_addr, err_wr=s_wreq, both captured in the abort cycle.
  - err_cnt increments on abort and saturates at 2^CWIDTH-1.
  - err_clr alone sets err_cnt to 0. err_addr and err_wr are held until the next abort.
- While reset=1: m_wreq=m_rreq=0, s_rdyn=1, s_rdat=m_rdat.
- Reset mid-transaction: the state returns to PASS and cnt to 0. The stall window restarts on the first cycle after reset is released.
- TIMEOUT=0: the block never aborts and never enters BLANK. err_cnt stays 0.

Test Plan:
- TIMEOUT=4, read addr 0x12, slave rdyn=1 for 2 cycles then 0 with rdat=0x5A -> master sees s_rdyn 1,1,0 and s_rdat=0x5A; err_pulse stays 0.
- TIMEOUT=4, ERRDATA=0xDE, read addr 0x34, slave rdyn stuck at 1 -> s_rdyn=0 with s_rdat=0xDE in the 5th cycle; m_rreq=0 in that cycle and the next (BLANK); next cycle err_pulse=1, err_addr=0x34, err_wr=0, err_cnt=1.
- TIMEOUT=4, write addr 0x56, slave drops rdyn exactly in the 5th cycle -> normal completion, no abort, err_cnt unchanged.
- Back-to-back write stalled forever then new read completing immediately -> abort, 1 BLANK cycle with s_rdyn=1, then the read passes through with zero latency.
- CWIDTH=2, 5 consecutive aborts -> err_cnt 1,2,3,3,3; err_clr together with the 6th abort -> err_cnt=1; err_clr alone -> 0.
- Reset asserted in the 3rd stalled cycle, then released with the slave still stalled -> m_rreq=0 during reset; abort occurs 5 stalled cycles after release; TIMEOUT=0 run with a stuck slave -> never aborts.
